// File: rtl/pc_branch_unit_pkg.sv
// ----------------------------------------------------------------------------
// pc_branch_unit_pkg : shared CPU encodings for the PC / branch unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pc_branch_unit_pkg;

  localparam int WORD_W = 16;

  // Bit positions on {N,V,Z} flag buses
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    CC_NE     = 3'd0,
    CC_EQ     = 3'd1,
    CC_GT     = 3'd2,
    CC_LT     = 3'd3,
    CC_GTE    = 3'd4,
    CC_LTE    = 3'd5,
    CC_OVFL   = 3'd6,
    CC_UNCOND = 3'd7
  } ccc_e;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    WAIT_FLAGS = 2'd1,
    HALTED     = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pc_branch_unit_if.sv
// ----------------------------------------------------------------------------
// pc_branch_unit_if : decode/flag inputs and fetch/hazard outputs of the unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface pc_branch_unit_if #(
  parameter int IMM_W = 9
);
  logic             stall_in;
  logic             br_valid_id;
  logic             br_reg_id;
  logic [2:0]       ccc_id;
  logic [IMM_W-1:0] imm_id;
  logic [15:0]      rs_data_id;
  logic             hlt_id;
  logic             flag_wr_ex;
  logic             N_flag;
  logic             Z_flag;
  logic             V_flag;
  logic [15:0]      pc;
  logic [15:0]      pc_plus2;
  logic             branch_taken;
  logic             flush;
  logic             stall_out;
  logic             halted;

  modport master (
    output stall_in, br_valid_id, br_reg_id, ccc_id, imm_id, rs_data_id,
           hlt_id, flag_wr_ex, N_flag, Z_flag, V_flag,
    input  pc, pc_plus2, branch_taken, flush, stall_out, halted
  );

  modport slave (
    input  stall_in, br_valid_id, br_reg_id, ccc_id, imm_id, rs_data_id,
           hlt_id, flag_wr_ex, N_flag, Z_flag, V_flag,
    output pc, pc_plus2, branch_taken, flush, stall_out, halted
  );
endinterface

`default_nettype wire

// File: rtl/pc_branch_unit_branch_cond_eval.sv
// ----------------------------------------------------------------------------
// branch_cond_eval : condition code plus {N,V,Z} flags to branch condition
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module branch_cond_eval
  import pc_branch_unit_pkg::*;
(
  input  wire logic [2:0] i_ccc,
  input  wire logic [2:0] i_flags,
  output logic            o_cond
);

  logic w_n;
  logic w_v;
  logic w_z;

  assign w_n = i_flags[FLAG_N];
  assign w_v = i_flags[FLAG_V];
  assign w_z = i_flags[FLAG_Z];

  always_comb begin
    o_cond = 1'b0;
    case (ccc_e'(i_ccc))
      CC_NE:     o_cond = ~w_z;
      CC_EQ:     o_cond = w_z;
      CC_GT:     o_cond = ~w_z & ~w_n;
      CC_LT:     o_cond = w_n;
      CC_GTE:    o_cond = w_z | ~w_n;
      CC_LTE:    o_cond = w_n | w_z;
      CC_OVFL:   o_cond = w_v;
      CC_UNCOND: o_cond = 1'b1;
      default:   o_cond = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_branch_unit.sv
// ----------------------------------------------------------------------------
// pc_branch_unit : program counter, decode-stage branch resolution, flag
//                  hazard interlock and HLT freeze.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          IMM_W    = 9
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  pc_branch_unit_if.slave bus
);

  state_e              r_state;
  state_e              w_state_next;
  logic [WORD_W-1:0]   r_pc;
  logic                r_halted;
  logic [WORD_W-1:0]   w_pc_next;
  logic [WORD_W-1:0]   w_pc_plus2;
  logic [WORD_W-1:0]   w_imm_sext;
  logic [WORD_W-1:0]   w_target;
  logic [2:0]          w_flags;
  logic                w_cond;
  logic                w_active;
  logic                w_br;
  logic                w_hazard;
  logic                w_hlt_go;
  logic                w_eval;
  logic                w_taken;
  logic                w_wen;

  assign w_flags = {bus.N_flag, bus.V_flag, bus.Z_flag};

  branch_cond_eval u_cond (
    .i_ccc   (bus.ccc_id),
    .i_flags (w_flags),
    .o_cond  (w_cond)
  );

  // Outputs are forced low during reset and whenever stall_in is up
  assign w_active = rst_n & ~bus.stall_in;
  assign w_br     = bus.br_valid_id & ~bus.hlt_id;
  assign w_hazard = w_active & (r_state == RUN) & w_br & bus.flag_wr_ex;
  assign w_hlt_go = w_active & (r_state == RUN) & bus.hlt_id;
  assign w_eval   = w_active & w_br &
                    (((r_state == RUN) & ~bus.flag_wr_ex) | (r_state == WAIT_FLAGS));
  assign w_taken  = w_eval & w_cond;

  assign w_pc_plus2 = r_pc + 16'd2;
  assign w_imm_sext = {{(WORD_W-IMM_W){bus.imm_id[IMM_W-1]}}, bus.imm_id};
  assign w_target   = bus.br_reg_id ? bus.rs_data_id
                                    : w_pc_plus2 + {w_imm_sext[WORD_W-2:0], 1'b0};

  assign w_wen = ~bus.stall_in & (r_state != HALTED);

  always_comb begin
    w_pc_next = w_pc_plus2;
    if (w_hazard || w_hlt_go) begin
      w_pc_next = r_pc;
    end else if (w_taken) begin
      w_pc_next = w_target;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN: begin
        if (bus.hlt_id) begin
          w_state_next = HALTED;
        end else if (w_br && bus.flag_wr_ex) begin
          w_state_next = WAIT_FLAGS;
        end
      end
      WAIT_FLAGS: w_state_next = RUN;
      HALTED:     w_state_next = HALTED;
      default:    w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else begin
      if (w_wen) begin
        r_pc <= w_pc_next;
      end
      if (!bus.stall_in) begin
        r_state  <= w_state_next;
        r_halted <= (w_state_next == HALTED);
      end
    end
  end

  assign bus.pc           = r_pc;
  assign bus.pc_plus2     = w_pc_plus2;
  assign bus.branch_taken = w_taken;
  assign bus.flush        = w_taken;
  assign bus.stall_out    = w_hazard;
  assign bus.halted       = r_halted;

endmodule

`default_nettype wire
